// File: rtl/serializer_pkg.sv
// Shared definitions for the LED pattern serializer: FSM state encoding,
// default geometry and counter widths sized for the legal parameter maxima.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HALF   = 2;
    localparam int BIT_CNT_W  = 5;   // holds WIDTH-1 for WIDTH up to 32
    localparam int HALF_CNT_W = 8;   // holds HALF-1 for HALF up to 255

endpackage

// File: rtl/half_period_timer.sv
// Free-running divider: one-cycle tick every HALF enabled cycles, count
// cleared whenever the enable is low.
module half_period_timer
    import serializer_pkg::*;
#(
    parameter int HALF = DEF_HALF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [HALF_CNT_W-1:0] CNT_LAST = HALF_CNT_W'(HALF - 1);

    logic [HALF_CNT_W-1:0] cnt_q;
    logic [HALF_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pattern_serializer.sv
// Shifts a WIDTH-bit word MSB first to an external LED shift driver, then
// strobes its storage latch. All outputs come straight from registers.
module pattern_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HALF  = DEF_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             done
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic                 phase_q, phase_d;
    logic                 sclk_q, sclk_d;
    logic                 sdata_q, sdata_d;
    logic                 latch_q, latch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timer_en;
    logic                 tick;

    // The timer runs continuously across SHIFT and LATCH so the latch phase
    // inherits the same HALF-cycle cadence without a restart gap.
    assign timer_en = (state_q == ST_SHIFT) || (state_q == ST_LATCH);

    half_period_timer #(
        .HALF (HALF)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (timer_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d  = 1'b0;
                latch_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_SHIFT;
                    shreg_d = data;
                    sdata_d = data[WIDTH-1];
                    bit_d   = '0;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            // Last bit stays on sdata through the latch strobe.
                            state_d = ST_LATCH;
                            latch_d = 1'b1;
                            bit_d   = '0;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                            sdata_d = shreg_q[WIDTH-2];
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_d = ST_DONE;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: a 16-bit/HALF=2 instance and a
// 2-bit/HALF=1 corner instance, each with its own monitor.
module tb_pattern_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [15:0] data;
    logic [1:0]  data2;
    logic        sclk, sdata, latch, busy, done;
    logic        sclk2, sdata2, latch2, busy2, done2;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int dc0;
    bit b2b_mode   = 1'b0;

    logic [15:0] exp_q[$];
    logic [1:0]  exp2_q[$];

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(16), .HALF(2)) dut (
        .clk(clk), .reset(rst_n), .start(start), .data(data),
        .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .done(done)
    );

    pattern_serializer #(.WIDTH(2), .HALF(1)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .data(data2),
        .sclk(sclk2), .sdata(sdata2), .latch(latch2), .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return busy;
            1:       return done;
            2:       return latch;
            default: return done2;
        endcase
    endfunction

    task automatic wait_lvl(input string name, input int which, input logic lvl, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (sig(which) == lvl) return;
        end
        check({"timeout_", name}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input bit push);
        @(negedge clk);
        #1;
        start = 1'b1;
        data  = d;
        if (push) exp_q.push_back(d);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor for the 16-bit instance
    logic [15:0] m_bits;
    int m_n, m_busy, m_latch, m_since, m_acc, m_gap;
    bit m_space_bad, m_gap_track, m_prev_sclk, m_prev_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_bits = '0; m_n = 0; m_busy = 0; m_latch = 0; m_since = 0; m_acc = 0;
            m_space_bad = 0; m_gap_track = 0; m_gap = 0; m_prev_sclk = 0; m_prev_busy = 0;
        end else begin
            if (busy && !m_prev_busy) begin
                m_acc = 1;
                if (b2b_mode && m_gap_track) check("idle_gap", m_gap, 1);
                m_gap_track = 0;
            end else begin
                m_acc++;
            end
            if (m_gap_track && !busy && !done) m_gap++;
            if (busy) m_busy++;
            if (latch) m_latch++;
            if (sclk && !m_prev_sclk) begin
                if (m_n > 0 && m_since != 4) m_space_bad = 1;
                m_bits = {m_bits[14:0], sdata};
                m_n++;
                m_since = 0;
            end
            m_since++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("word", m_bits, e);
                    check("bit_count", m_n, 16);
                    check("busy_cycles", m_busy, 66);
                    check("latch_cycles", m_latch, 2);
                    check("sclk_spacing", m_space_bad, 0);
                    check("done_cycle", m_acc, 67);
                end
                m_bits = '0; m_n = 0; m_busy = 0; m_latch = 0; m_space_bad = 0;
                m_gap_track = 1; m_gap = 0;
            end
            m_prev_sclk = sclk;
            m_prev_busy = busy;
        end
    end

    // Monitor for the 2-bit corner instance
    logic [1:0] m2_bits;
    int m2_n, m2_busy, m2_latch, m2_tog, m2_acc;
    bit m2_prev_sclk, m2_prev_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m2_bits = '0; m2_n = 0; m2_busy = 0; m2_latch = 0; m2_tog = 0; m2_acc = 0;
            m2_prev_sclk = 0; m2_prev_busy = 0;
        end else begin
            if (busy2 && !m2_prev_busy) m2_acc = 1;
            else m2_acc++;
            if (busy2) m2_busy++;
            if (latch2) m2_latch++;
            if (sclk2 != m2_prev_sclk) m2_tog++;
            if (sclk2 && !m2_prev_sclk) begin
                m2_bits = {m2_bits[0], sdata2};
                m2_n++;
            end
            if (done2) begin
                if (exp2_q.size() == 0) begin
                    check("unexpected_done2", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e2;
                    e2 = exp2_q.pop_front();
                    check("c_word", m2_bits, e2);
                    check("c_bit_count", m2_n, 2);
                    check("c_busy_cycles", m2_busy, 5);
                    check("c_latch_cycles", m2_latch, 1);
                    check("c_sclk_toggles", m2_tog, 4);
                    check("c_done_cycle", m2_acc, 6);
                end
                m2_bits = '0; m2_n = 0; m2_busy = 0; m2_latch = 0; m2_tog = 0;
            end
            m2_prev_sclk = sclk2;
            m2_prev_busy = busy2;
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; data = '0; start2 = 1'b0; data2 = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {sclk, sdata, latch, busy, done, sclk2, sdata2, latch2, busy2, done2}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_quiet", {sclk, sdata, latch, busy, done}, 0);
        end

        send(16'hA5C3, 1'b1);
        wait_lvl("done_a5c3", 1, 1'b1, 100);
        repeat (2) @(negedge clk);

        dc0 = done_cnt;
        send(16'h0000, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        start = 1'b1;
        data  = 16'hFFFF;
        @(negedge clk);
        #1;
        start = 1'b0;
        data  = 16'h0000;
        wait_lvl("done_zero", 1, 1'b1, 100);
        repeat (10) @(negedge clk);
        check("single_done", done_cnt - dc0, 1);

        #1;
        start = 1'b1;
        data  = 16'h0001;
        exp_q.push_back(16'h0001);
        wait_lvl("b2b_busy1", 0, 1'b1, 10);
        b2b_mode = 1'b1;
        data = 16'h8000;
        exp_q.push_back(16'h8000);
        wait_lvl("b2b_fall1", 0, 1'b0, 100);
        wait_lvl("b2b_busy2", 0, 1'b1, 10);
        data = 16'h0001;
        exp_q.push_back(16'h0001);
        wait_lvl("b2b_fall2", 0, 1'b0, 100);
        wait_lvl("b2b_busy3", 0, 1'b1, 10);
        start = 1'b0;
        b2b_mode = 1'b0;
        wait_lvl("done_b2b", 1, 1'b1, 100);
        repeat (2) @(negedge clk);

        dc0 = done_cnt;
        send(16'h1234, 1'b0);
        wait_lvl("latch_rise", 2, 1'b1, 100);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {sclk, sdata, latch, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);

        @(negedge clk);
        #1;
        start2 = 1'b1;
        data2  = 2'b10;
        exp2_q.push_back(2'b10);
        @(negedge clk);
        #1;
        start2 = 1'b0;
        wait_lvl("done_corner", 3, 1'b1, 20);
        repeat (3) @(negedge clk);

        check("queues_empty", exp_q.size() + exp2_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the number of bits per transmitted word (legal range 2..32).
REQ-002 Parameter HALF, default 2, SHALL set the clk cycles per half period of sclk (legal range 1..255).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; every register changes only on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-005 Port start, input, 1 bit, SHALL request transmission of data.
REQ-006 Port data, input, WIDTH bits, SHALL be the word to send, sampled only when a start is accepted.
REQ-007 Port sclk, output, 1 bit, SHALL be the serial clock to the external LED shift driver.
REQ-008 Port sdata, output, 1 bit, SHALL be the serial data, sent MSB first.
REQ-009 Port latch, output, 1 bit, SHALL be the storage-latch strobe to the external driver.
REQ-010 Port busy, output, 1 bit, SHALL be high while a word is in flight.
REQ-011 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, LATCH and DONE.
REQ-013 In IDLE, if start=1 at a rising edge, the block SHALL load data into the shift register and move to SHIFT; busy SHALL be 1 from the next cycle.
REQ-014 A start seen in any state other than IDLE SHALL be ignored, with no queueing and no effect on the word in flight.
REQ-015 In SHIFT, each bit SHALL occupy 2*HALF cycles: sclk=0 for the first HALF cycles, then sclk=1 for HALF cycles.
REQ-016 sdata SHALL show the current MSB of the shift register and SHALL change only on the cycle where sclk goes 1->0 (or on entry to SHIFT), so it is stable across every sclk rising edge.
REQ-017 After WIDTH bit periods, the FSM SHALL go to LATCH: sclk=0 and latch=1 for exactly HALF cycles, and sdata SHALL hold the last bit.
REQ-018 After LATCH, the FSM SHALL spend one cycle in DONE (done=1, busy=0, latch=0), then return to IDLE.
REQ-019 busy SHALL be high for exactly WIDTH*2*HALF + HALF cycles per word.
REQ-020 A start seen during the DONE cycle SHALL be ignored; the earliest accepted start is the first IDLE cycle after DONE.
REQ-021 Bit and half-period counters SHALL be sized for the parameter maxima and SHALL reach exactly WIDTH-1 and HALF-1 before wrapping to 0, with no off-by-one.
REQ-022 In IDLE, sclk=0, latch=0, done=0, busy=0, and sdata SHALL hold its last value.

Reset
REQ-023 When reset=0, the block SHALL immediately (asynchronously) enter IDLE, with sclk=0, sdata=0, latch=0, busy=0, done=0 and all counters and the shift register at 0.
REQ-024 A reset asserted mid-word SHALL abort the word; no latch pulse and no done pulse SHALL follow.
REQ-025 The first start SHALL be accepted no earlier than the first rising edge after reset returns to 1.

Structure
REQ-026 The state enum and the default WIDTH/HALF constants SHALL live in the shared package serializer_pkg.
REQ-027 The half-period timing SHALL be a sub-module, half_period_timer, which emits a one-cycle tick every HALF cycles while enabled and resets its count when disabled.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from start or data to any output.

Verification
REQ-029 Reset then idle: hold reset=0 for 3 cycles, then release -> all outputs are 0, and with start=0 for 10 cycles nothing toggles.
REQ-030 Single word: WIDTH=16, HALF=2, data=16'hA5C3, one-cycle start -> 16 sclk rising edges at 4-cycle spacing; sdata sampled at each rising edge = 1010_0101_1100_0011; latch high for 2 cycles; done pulses on cycle 67 after the accept; busy high for 66 cycles.
REQ-031 Ignored start: pulse start with data=16'hFFFF during bit 5 of a 16'h0000 word -> the shifted stream stays all zeros and there is exactly one done pulse.
REQ-032 Back-to-back: hold start=1 continuously with data alternating 16'h0001 and 16'h8000 -> the words are sent in sequence, with exactly one IDLE cycle between DONE and the next SHIFT.
REQ-033 Reset mid-word: assert reset=0 during LATCH -> latch drops asynchronously, and no done pulse follows.
REQ-034 Parameter corner: WIDTH=2, HALF=1, data=2'b10 -> sclk toggles every cycle, sdata reads 1 then 0, latch is high for 1 cycle, and busy is high for 5 cycles.
